// File: rtl/pipe_pkg.sv
// Shared types and helpers for the ID-stage hazard/forwarding tracker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_pkg;

    // Widest register address the shadow entries can hold; narrower
    // addresses are zero-extended into the entry.
    localparam int RA_MAX = 16;

    // fwd_sel value meaning "take the operand from the register file".
    localparam int FWD_RF = 0;

    // One shadow pipeline slot: destination info of the instruction in a stage.
    typedef struct packed {
        logic              valid;
        logic [RA_MAX-1:0] rd;
        logic              we;
        logic              ld;
    } entry_t;

    // Width of a per-port forwarding select: encodes 0 (RF) .. depth (stage).
    function automatic int sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_hazard_track_if.sv
// Decode-side bundle between the ID stage and the hazard tracker.
// Latency: n/a (wires only); responses are combinational in the tracker.
// Backpressure: stall_needed tells ID/PC to hold; ext_stall freezes the tracker.
// Ports: master = ID stage (drives decode info), slave = tracker (drives results).
interface pipe_hazard_track_if #(
    parameter int RA_W  = 5,
    parameter int NREAD = 2,
    parameter int DEPTH = 3
);
    import pipe_pkg::*;

    localparam int SELW = sel_w(DEPTH);

    logic                    id_valid;
    logic [NREAD*RA_W-1:0]   id_rs;
    logic [NREAD-1:0]        id_rs_used;
    logic [RA_W-1:0]         id_rd;
    logic                    id_reg_write;
    logic                    id_is_load;
    logic                    flush;
    logic                    ext_stall;
    logic                    stall_needed;
    logic [NREAD*SELW-1:0]   fwd_sel;
    logic [15:0]             stall_cycles;

    modport master (
        output id_valid, id_rs, id_rs_used, id_rd, id_reg_write, id_is_load,
               flush, ext_stall,
        input  stall_needed, fwd_sel, stall_cycles
    );

    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rd, id_reg_write, id_is_load,
               flush, ext_stall,
        output stall_needed, fwd_sel, stall_cycles
    );

endinterface

// File: rtl/hazard_match.sv
// Priority search of the shadow stages for one decode source operand.
// Latency: combinational.
// Backpressure: none; o_hazard feeds the decode stall in the parent.
// Ports: i_ent (stage k at index k-1), i_rs/i_used (operand), o_hit/o_k/o_hazard.
module hazard_match
    import pipe_pkg::*;
#(
    parameter  int RA_W       = 5,
    parameter  int DEPTH      = 3,
    parameter  int LOAD_STAGE = 2,
    localparam int SELW       = sel_w(DEPTH)
) (
    input  entry_t [DEPTH-1:0] i_ent,
    input  logic   [RA_W-1:0]  i_rs,
    input  logic               i_used,
    output logic               o_hit,
    output logic   [SELW-1:0]  o_k,
    output logic               o_hazard
);

    // Scan oldest to youngest so the last hit written is the smallest k.
    // rs==0 is excluded up front, which also keeps rd==0 writers from matching.
    always_comb begin
        o_hit    = 1'b0;
        o_k      = '0;
        o_hazard = 1'b0;
        if (i_used && (i_rs != '0)) begin
            for (int k = DEPTH; k >= 1; k--) begin
                if (i_ent[k-1].valid && i_ent[k-1].we &&
                    (i_ent[k-1].rd == RA_MAX'(i_rs))) begin
                    o_hit    = 1'b1;
                    o_k      = SELW'(k);
                    // Load data not yet available at this stage.
                    o_hazard = i_ent[k-1].ld && (k < LOAD_STAGE);
                end
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_track.sv
// Shadow shift register of post-ID destinations; per-port forward select and load-use stall.
// Latency: fwd_sel/stall_needed combinational in the decode cycle; entries update on clk.
// Backpressure: ext_stall freezes all entries and the counter; hazard inserts a bubble.
// Ports: clk, rst (async active-low), bus (slave side of pipe_hazard_track_if).
module pipe_hazard_track
    import pipe_pkg::*;
#(
    parameter int RA_W       = 5,
    parameter int NREAD      = 2,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    pipe_hazard_track_if.slave    bus
);

    localparam int SELW = sel_w(DEPTH);

    entry_t [DEPTH-1:0] r_ent;          // index k-1 holds stage k
    logic   [15:0]      r_stall_cycles;

    logic               w_hit    [NREAD];
    logic   [SELW-1:0]  w_k      [NREAD];
    logic   [NREAD-1:0] w_port_hz;
    logic               w_hazard;
    logic               w_issue;
    entry_t             w_new;

    for (genvar p = 0; p < NREAD; p++) begin : g_port
        hazard_match #(
            .RA_W       (RA_W),
            .DEPTH      (DEPTH),
            .LOAD_STAGE (LOAD_STAGE)
        ) u_match (
            .i_ent    (r_ent),
            .i_rs     (bus.id_rs[p*RA_W +: RA_W]),
            .i_used   (bus.id_rs_used[p]),
            .o_hit    (w_hit[p]),
            .o_k      (w_k[p]),
            .o_hazard (w_port_hz[p])
        );
    end

    // Flush beats hazard: a killed instruction cannot stall decode.
    assign w_hazard = bus.id_valid && !bus.flush && (|w_port_hz);
    assign w_issue  = bus.id_valid && !bus.flush && !w_hazard;

    always_comb begin
        w_new       = '0;
        w_new.valid = w_issue;
        w_new.rd    = RA_MAX'(bus.id_rd);
        w_new.we    = bus.id_reg_write;
        w_new.ld    = bus.id_is_load;
    end

    // A hazarding port reads the RF select; the stall makes the value moot.
    always_comb begin
        bus.fwd_sel = '0;
        for (int p = 0; p < NREAD; p++) begin
            bus.fwd_sel[p*SELW +: SELW] = (w_hit[p] && !w_port_hz[p]) ? w_k[p]
                                                                      : SELW'(FWD_RF);
        end
    end

    assign bus.stall_needed = w_hazard || bus.ext_stall;
    assign bus.stall_cycles = r_stall_cycles;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ent          <= '0;
            r_stall_cycles <= '0;
        end else if (!bus.ext_stall) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                r_ent[k] <= r_ent[k-1];
            end
            r_ent[0] <= w_new;
            if (w_hazard && (r_stall_cycles != 16'hFFFF)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_track.sv
// Drives two tracker configurations (defaults, and DEPTH=4/LOAD_STAGE=3) with the
// same decode stream; a reference model predicts each cycle's outputs into a
// scoreboard queue that a separate monitor drains on the falling edge.
module tb_pipe_hazard_track;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_track_if #(.RA_W(5), .NREAD(2), .DEPTH(3)) bus_a ();
    pipe_hazard_track_if #(.RA_W(5), .NREAD(2), .DEPTH(4)) bus_b ();

    pipe_hazard_track #(.RA_W(5), .NREAD(2), .DEPTH(3), .LOAD_STAGE(2)) dut_a (
        .clk (clk),
        .rst (rst_n),
        .bus (bus_a)
    );

    pipe_hazard_track #(.RA_W(5), .NREAD(2), .DEPTH(4), .LOAD_STAGE(3)) dut_b (
        .clk (clk),
        .rst (rst_n),
        .bus (bus_b)
    );

    // Currently applied decode inputs (shared by both DUTs).
    bit       t_v, t_fl, t_es, t_we, t_ld;
    bit       t_rstn = 1'b0;
    int       t_rs0, t_rs1, t_rd;
    bit [1:0] t_used;

    // Reference model: per configuration, a list of the instructions in flight
    // after ID, position 0 = the youngest (EX).
    typedef struct {
        bit v;
        int rd;
        bit we;
        bit ld;
    } minst_t;

    minst_t m_pipe [2][4];
    int     m_cnt  [2];

    typedef struct {
        bit st_a; int f0_a; int f1_a; int cnt_a;
        bit st_b; int f0_b; int f1_b; int cnt_b;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int depth_of(int i);
        return (i == 0) ? 3 : 4;
    endfunction

    function automatic int lstage_of(int i);
        return (i == 0) ? 2 : 3;
    endfunction

    // Forwarding source for one operand: nearest in-flight writer of rs.
    function automatic int port_sel(int i, int rs, bit used, output bit hz);
        hz = 1'b0;
        if (!used || rs == 0) return 0;
        for (int pos = 0; pos < depth_of(i); pos++) begin
            if (m_pipe[i][pos].v && m_pipe[i][pos].we && m_pipe[i][pos].rd == rs) begin
                if (m_pipe[i][pos].ld && (pos + 1) < lstage_of(i)) begin
                    hz = 1'b1;
                    return 0;
                end
                return pos + 1;
            end
        end
        return 0;
    endfunction

    function automatic bit hazard_of(int i);
        bit h0, h1;
        void'(port_sel(i, t_rs0, t_used[0], h0));
        void'(port_sel(i, t_rs1, t_used[1], h1));
        return t_v && !t_fl && (h0 || h1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0;
            for (int pos = 0; pos < 4; pos++) m_pipe[i][pos] = '{0, 0, 0, 0};
        end
    endtask

    task automatic model_clock(int i);
        bit     h;
        minst_t n;
        if (t_es) return;
        h = hazard_of(i);
        if (h && m_cnt[i] < 65535) m_cnt[i]++;
        n = '{0, 0, 0, 0};
        if (t_v && !t_fl && !h) n = '{1, t_rd, t_we, t_ld};
        for (int pos = depth_of(i) - 1; pos > 0; pos--) m_pipe[i][pos] = m_pipe[i][pos-1];
        m_pipe[i][0] = n;
    endtask

    task automatic apply_inputs();
        bus_a.id_valid     = t_v;
        bus_a.id_rs        = {t_rs1[4:0], t_rs0[4:0]};
        bus_a.id_rs_used   = t_used;
        bus_a.id_rd        = t_rd[4:0];
        bus_a.id_reg_write = t_we;
        bus_a.id_is_load   = t_ld;
        bus_a.flush        = t_fl;
        bus_a.ext_stall    = t_es;
        bus_b.id_valid     = t_v;
        bus_b.id_rs        = {t_rs1[4:0], t_rs0[4:0]};
        bus_b.id_rs_used   = t_used;
        bus_b.id_rd        = t_rd[4:0];
        bus_b.id_reg_write = t_we;
        bus_b.id_is_load   = t_ld;
        bus_b.flush        = t_fl;
        bus_b.ext_stall    = t_es;
    endtask

    task automatic push_expect();
        exp_t e;
        bit   hz;
        e.st_a  = hazard_of(0) || t_es;
        e.f0_a  = port_sel(0, t_rs0, t_used[0], hz);
        e.f1_a  = port_sel(0, t_rs1, t_used[1], hz);
        e.cnt_a = m_cnt[0];
        e.st_b  = hazard_of(1) || t_es;
        e.f0_b  = port_sel(1, t_rs0, t_used[0], hz);
        e.f1_b  = port_sel(1, t_rs1, t_used[1], hz);
        e.cnt_b = m_cnt[1];
        sb.push_back(e);
    endtask

    // One decode cycle: retire the previous cycle's inputs into the model at the
    // edge, then present new inputs (and reset level) and predict the outputs.
    task automatic issue(bit v, int rs0, int rs1, bit [1:0] used, int rd,
                         bit we, bit ld, bit fl, bit es, bit rn);
        @(posedge clk);
        if (t_rstn) begin
            model_clock(0);
            model_clock(1);
        end
        #1;
        t_v = v; t_rs0 = rs0; t_rs1 = rs1; t_used = used; t_rd = rd;
        t_we = we; t_ld = ld; t_fl = fl; t_es = es; t_rstn = rn;
        rst_n = rn;
        if (!rn) model_reset();
        apply_inputs();
        push_expect();
    endtask

    task automatic idle(bit es);
        issue(0, 0, 0, 2'b00, 0, 0, 0, 0, es, 1);
    endtask

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: the DUT presents a decode response every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("a_stall",  int'(bus_a.stall_needed),  int'(e.st_a));
                check("a_fwd0",   int'(bus_a.fwd_sel[1:0]),  e.f0_a);
                check("a_fwd1",   int'(bus_a.fwd_sel[3:2]),  e.f1_a);
                check("a_cycles", int'(bus_a.stall_cycles),  e.cnt_a);
                check("b_stall",  int'(bus_b.stall_needed),  int'(e.st_b));
                check("b_fwd0",   int'(bus_b.fwd_sel[2:0]),  e.f0_b);
                check("b_fwd1",   int'(bus_b.fwd_sel[5:3]),  e.f1_b);
                check("b_cycles", int'(bus_b.stall_cycles),  e.cnt_b);
            end
        end
    end

    initial begin
        t_v = 0; t_rs0 = 0; t_rs1 = 0; t_used = 0; t_rd = 0;
        t_we = 0; t_ld = 0; t_fl = 0; t_es = 0;
        model_reset();
        apply_inputs();

        // Reset and post-reset empty pipe; stall mirrors ext_stall.
        issue(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        issue(0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0);
        issue(1, 5, 6, 2'b11, 1, 1, 0, 0, 1, 1);
        idle(0);

        // ALU producer then consumer: forward from EX.
        issue(1, 0, 0, 2'b00, 5, 1, 0, 0, 0, 1);
        issue(1, 5, 0, 2'b01, 6, 1, 0, 0, 0, 1);

        // Load-use: consumer held while stalled.
        issue(1, 0, 0, 2'b00, 8, 1, 1, 0, 0, 1);
        repeat (3) issue(1, 8, 0, 2'b01, 9, 1, 0, 0, 0, 1);
        repeat (3) idle(0);

        // Youngest writer wins; register 0 never forwards.
        issue(1, 0, 0, 2'b00, 7, 1, 0, 0, 0, 1);
        issue(1, 0, 0, 2'b00, 9, 1, 0, 0, 0, 1);
        issue(1, 0, 0, 2'b00, 7, 1, 0, 0, 0, 1);
        issue(1, 7, 7, 2'b11, 2, 1, 0, 0, 0, 1);
        issue(1, 0, 0, 2'b00, 0, 1, 0, 0, 0, 1);
        issue(1, 0, 0, 2'b11, 3, 1, 0, 0, 0, 1);
        repeat (3) idle(0);

        // Hazard with flush in the same cycle.
        issue(1, 0, 0, 2'b00, 4, 1, 1, 0, 0, 1);
        issue(1, 0, 4, 2'b10, 5, 1, 0, 1, 0, 1);
        issue(1, 4, 0, 2'b01, 5, 1, 0, 0, 0, 1);
        repeat (3) idle(0);

        // Freeze with a pending load-use.
        issue(1, 0, 0, 2'b00, 4, 1, 1, 0, 0, 1);
        repeat (3) issue(1, 4, 0, 2'b01, 5, 1, 0, 0, 1, 1);
        repeat (3) issue(1, 4, 0, 2'b01, 5, 1, 0, 0, 0, 1);
        repeat (2) idle(0);

        // Reset during a load-use stall.
        issue(1, 0, 0, 2'b00, 6, 1, 1, 0, 0, 1);
        issue(1, 6, 0, 2'b01, 7, 1, 0, 0, 0, 1);
        issue(1, 6, 0, 2'b01, 7, 1, 0, 0, 0, 0);
        issue(1, 6, 0, 2'b01, 7, 1, 0, 0, 0, 1);
        idle(0);

        // Randomised decode stream over a small register pool.
        for (int n = 0; n < 600; n++) begin
            issue($urandom_range(0, 7) != 0,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 99) != 0);
        end
        idle(0);

        repeat (3) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
